// File: rtl/reset_sequencer_if.sv
// Reset-sequencer bundle: soft restart request, per-stage ready/reset and status.
// master is the sequencer side; slave is the downstream-domain / controller side.
interface reset_sequencer_if #(
  parameter int NUM_STAGES = 4
);
  logic                  soft_rst_req;
  logic [NUM_STAGES-1:0] stage_ready;
  logic [NUM_STAGES-1:0] stage_rst;
  logic                  seq_done;
  logic                  seq_error;
  logic [2:0]            err_stage;

  modport master (
    input  soft_rst_req,
    input  stage_ready,
    output stage_rst,
    output seq_done,
    output seq_error,
    output err_stage
  );

  modport slave (
    output soft_rst_req,
    output stage_ready,
    input  stage_rst,
    input  seq_done,
    input  seq_error,
    input  err_stage
  );
endinterface

// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES reset domains in ascending order after a fixed hold,
// waiting for each stage's ready with a timeout; faults re-assert every reset.
module reset_sequencer #(
  parameter int NUM_STAGES     = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                pll_clk,
  input  logic                sync_rst,
  reset_sequencer_if.master   bus
);

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_WAIT,
    ST_DONE,
    ST_ERROR
  } state_e;

  localparam logic [15:0]           HOLD_LAST    = 16'(HOLD_CYCLES);
  localparam logic [15:0]           TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]            LAST_IDX     = 3'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] ALL_ONES     = '1;

  state_e                state_q, state_d;
  logic [2:0]            idx_q, idx_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [NUM_STAGES-1:0] stage_rst_q, stage_rst_d;
  logic                  seq_done_q, seq_done_d;
  logic                  seq_error_q, seq_error_d;
  logic [2:0]            err_stage_q, err_stage_d;

  logic [7:0] ready_ext;
  logic [2:0] low_idx;
  logic       all_ready;

  // Zero-extend so idx can index ready for any NUM_STAGES without width games.
  always_comb begin
    ready_ext = '0;
    ready_ext[NUM_STAGES-1:0] = bus.stage_ready;
  end

  always_comb begin
    low_idx = '0;
    for (int i = NUM_STAGES - 1; i >= 0; i--) begin
      if (!bus.stage_ready[i]) low_idx = 3'(i);
    end
  end

  assign all_ready = &bus.stage_ready;

  // NOTE: every _d gets a default from its _q first, so no path leaves a latch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    stage_rst_d = stage_rst_q;
    seq_done_d  = seq_done_q;
    seq_error_d = seq_error_q;
    err_stage_d = err_stage_q;

    if (bus.soft_rst_req) begin
      state_d     = ST_HOLD;
      stage_rst_d = ALL_ONES;
      seq_done_d  = 1'b0;
      seq_error_d = 1'b0;
      err_stage_d = '0;
      idx_d       = '0;
      cnt_d       = '0;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          stage_rst_d = ALL_ONES;
          // cnt holds the number of hold edges already taken.
          if (cnt_q == HOLD_LAST) begin
            stage_rst_d = ALL_ONES << 1;
            idx_d       = '0;
            cnt_d       = '0;
            state_d     = ST_WAIT;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end

        ST_WAIT: begin
          if (ready_ext[idx_q]) begin
            cnt_d = '0;
            if (idx_q == LAST_IDX) begin
              state_d    = ST_DONE;
              seq_done_d = 1'b1;
            end else begin
              // Released stages form a low contiguous run; shifting frees the next one.
              stage_rst_d = stage_rst_q << 1;
              idx_d       = idx_q + 3'd1;
            end
          end else if (cnt_q == TIMEOUT_LAST) begin
            state_d     = ST_ERROR;
            seq_error_d = 1'b1;
            seq_done_d  = 1'b0;
            err_stage_d = idx_q;
            stage_rst_d = ALL_ONES;
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end

        ST_DONE: begin
          if (!all_ready) begin
            state_d     = ST_ERROR;
            seq_error_d = 1'b1;
            seq_done_d  = 1'b0;
            err_stage_d = low_idx;
            stage_rst_d = ALL_ONES;
          end
        end

        ST_ERROR: begin
          stage_rst_d = ALL_ONES;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge pll_clk) begin
    if (sync_rst) begin
      state_q     <= ST_HOLD;
      idx_q       <= '0;
      cnt_q       <= '0;
      stage_rst_q <= ALL_ONES;
      seq_done_q  <= 1'b0;
      seq_error_q <= 1'b0;
      err_stage_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      stage_rst_q <= stage_rst_d;
      seq_done_q  <= seq_done_d;
      seq_error_q <= seq_error_d;
      err_stage_q <= err_stage_d;
    end
  end

  assign bus.stage_rst = stage_rst_q;
  assign bus.seq_done  = seq_done_q;
  assign bus.seq_error = seq_error_q;
  assign bus.err_stage = err_stage_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: a default 4-stage instance and a
// 1-stage / 1-cycle-hold / 1-cycle-timeout instance, checked through a scoreboard queue.
module tb_reset_sequencer;

  typedef struct {
    string      tag;
    bit         which;
    logic [3:0] rst;
    logic       done;
    logic       err;
    logic [2:0] es;
  } exp_t;

  logic pll_clk = 1'b0;
  logic sync_rst;
  logic sync_rst1;
  bit   chk_en = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb_q[$];

  always #5 pll_clk = ~pll_clk;

  reset_sequencer_if bus ();
  reset_sequencer_if #(.NUM_STAGES(1)) bus1 ();

  reset_sequencer dut (
    .pll_clk  (pll_clk),
    .sync_rst (sync_rst),
    .bus      (bus)
  );

  reset_sequencer #(
    .NUM_STAGES     (1),
    .HOLD_CYCLES    (1),
    .TIMEOUT_CYCLES (1)
  ) dut1 (
    .pll_clk  (pll_clk),
    .sync_rst (sync_rst1),
    .bus      (bus1)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit ordered(input logic [3:0] v);
    ordered = 1'b1;
    for (int i = 1; i < 4; i++) begin
      if (v[i-1] === 1'b1 && v[i] !== 1'b1) ordered = 1'b0;
    end
  endfunction

  // Ascending release order must hold on every cycle of every scenario.
  always @(negedge pll_clk) begin
    if (chk_en) begin
      checks++;
      assert (ordered(bus.stage_rst) === 1'b1) else begin
        failures++;
        $error("FAIL order observed=%b expected=ascending", bus.stage_rst);
      end
    end
  end

  task automatic compare_pop();
    exp_t       e;
    logic [3:0] o_rst;
    logic       o_done;
    logic       o_err;
    logic [2:0] o_es;
    e = sb_q.pop_front();
    if (e.which) begin
      o_rst  = {3'b000, bus1.stage_rst};
      o_done = bus1.seq_done;
      o_err  = bus1.seq_error;
      o_es   = bus1.err_stage;
    end else begin
      o_rst  = bus.stage_rst;
      o_done = bus.seq_done;
      o_err  = bus.seq_error;
      o_es   = bus.err_stage;
    end
    check({e.tag, ".stage_rst"}, 8'(o_rst),  8'(e.rst));
    check({e.tag, ".seq_done"},  8'(o_done), 8'(e.done));
    check({e.tag, ".seq_error"}, 8'(o_err),  8'(e.err));
    check({e.tag, ".err_stage"}, 8'(o_es),   8'(e.es));
  endtask

  // Push the expectation for the coming edge, take the edge, then compare.
  task automatic step(input string tag, input bit which, input logic [3:0] rst,
                      input logic done, input logic err, input logic [2:0] es);
    exp_t e;
    e.tag   = tag;
    e.which = which;
    e.rst   = rst;
    e.done  = done;
    e.err   = err;
    e.es    = es;
    sb_q.push_back(e);
    @(posedge pll_clk);
    #1;
    compare_pop();
  endtask

  task automatic steps(input int n, input string tag, input bit which, input logic [3:0] rst,
                       input logic done, input logic err, input logic [2:0] es);
    for (int i = 0; i < n; i++) step(tag, which, rst, done, err, es);
  endtask

  // Full release from HOLD count 0 with every stage ready: 16 holds, then one stage per edge.
  task automatic full_sequence(input string tag);
    steps(16, {tag, "_hold"}, 1'b0, 4'hF, 1'b0, 1'b0, 3'd0);
    step({tag, "_rel0"}, 1'b0, 4'hE, 1'b0, 1'b0, 3'd0);
    step({tag, "_rel1"}, 1'b0, 4'hC, 1'b0, 1'b0, 3'd0);
    step({tag, "_rel2"}, 1'b0, 4'h8, 1'b0, 1'b0, 3'd0);
    step({tag, "_rel3"}, 1'b0, 4'h0, 1'b0, 1'b0, 3'd0);
    step({tag, "_done"}, 1'b0, 4'h0, 1'b1, 1'b0, 3'd0);
  endtask

  initial begin
    sync_rst          = 1'b1;
    sync_rst1         = 1'b1;
    bus.soft_rst_req  = 1'b0;
    bus.stage_ready   = 4'hF;
    bus1.soft_rst_req = 1'b0;
    bus1.stage_ready  = 1'b0;
    @(posedge pll_clk);
    #1;
    chk_en = 1'b1;

    // Reset values on both instances.
    step("reset", 1'b0, 4'hF, 1'b0, 1'b0, 3'd0);
    step("reset1", 1'b1, 4'h1, 1'b0, 1'b0, 3'd0);

    // Defaults, all ready: release at E+16..E+19, done at E+20.
    sync_rst = 1'b0;
    full_sequence("a");
    steps(3, "a_done_hold", 1'b0, 4'h0, 1'b1, 1'b0, 3'd0);

    // Stage 2 drops for one cycle while DONE.
    bus.stage_ready = 4'b1011;
    step("c_drop2", 1'b0, 4'hF, 1'b0, 1'b1, 3'd2);
    bus.stage_ready = 4'hF;
    steps(4, "c_err_hold", 1'b0, 4'hF, 1'b0, 1'b1, 3'd2);

    // Soft restart out of ERROR, then stage 1 never becomes ready.
    bus.stage_ready  = 4'b1101;
    bus.soft_rst_req = 1'b1;
    step("b_soft", 1'b0, 4'hF, 1'b0, 1'b0, 3'd0);
    bus.soft_rst_req = 1'b0;
    steps(16, "b_hold", 1'b0, 4'hF, 1'b0, 1'b0, 3'd0);
    step("b_rel0", 1'b0, 4'hE, 1'b0, 1'b0, 3'd0);
    steps(1024, "b_wait1", 1'b0, 4'hC, 1'b0, 1'b0, 3'd0);
    step("b_timeout", 1'b0, 4'hF, 1'b0, 1'b1, 3'd1);
    steps(20, "b_err_hold", 1'b0, 4'hF, 1'b0, 1'b1, 3'd1);

    // Soft restart from ERROR, then soft request on the very edge a timeout would fire.
    bus.soft_rst_req = 1'b1;
    step("d_soft_err", 1'b0, 4'hF, 1'b0, 1'b0, 3'd0);
    bus.soft_rst_req = 1'b0;
    steps(16, "d_hold", 1'b0, 4'hF, 1'b0, 1'b0, 3'd0);
    step("d_rel0", 1'b0, 4'hE, 1'b0, 1'b0, 3'd0);
    steps(1024, "d_wait1", 1'b0, 4'hC, 1'b0, 1'b0, 3'd0);
    bus.soft_rst_req = 1'b1;
    step("d_soft_vs_timeout", 1'b0, 4'hF, 1'b0, 1'b0, 3'd0);
    bus.soft_rst_req = 1'b0;
    bus.stage_ready  = 4'hF;
    full_sequence("d_restart");

    // Two stages drop in DONE: lowest index is reported.
    bus.stage_ready = 4'b0101;
    step("lowest_low", 1'b0, 4'hF, 1'b0, 1'b1, 3'd1);
    bus.stage_ready = 4'hF;

    // sync_rst from ERROR, then again mid-sequence at idx=2.
    sync_rst = 1'b1;
    step("e_rst_err", 1'b0, 4'hF, 1'b0, 1'b0, 3'd0);
    sync_rst = 1'b0;
    steps(16, "e_hold", 1'b0, 4'hF, 1'b0, 1'b0, 3'd0);
    step("e_rel0", 1'b0, 4'hE, 1'b0, 1'b0, 3'd0);
    step("e_rel1", 1'b0, 4'hC, 1'b0, 1'b0, 3'd0);
    step("e_rel2", 1'b0, 4'h8, 1'b0, 1'b0, 3'd0);
    sync_rst = 1'b1;
    step("e_rst_idx2", 1'b0, 4'hF, 1'b0, 1'b0, 3'd0);
    sync_rst = 1'b0;
    full_sequence("e_after");

    // Minimal instance: one stage, one-cycle hold, one-cycle timeout.
    sync_rst1 = 1'b0;
    step("f_hold", 1'b1, 4'h1, 1'b0, 1'b0, 3'd0);
    step("f_rel0", 1'b1, 4'h0, 1'b0, 1'b0, 3'd0);
    step("f_timeout", 1'b1, 4'h1, 1'b0, 1'b1, 3'd0);
    steps(3, "f_err_hold", 1'b1, 4'h1, 1'b0, 1'b1, 3'd0);
    bus1.soft_rst_req = 1'b1;
    bus1.stage_ready  = 1'b1;
    step("f_soft", 1'b1, 4'h1, 1'b0, 1'b0, 3'd0);
    bus1.soft_rst_req = 1'b0;
    step("f_hold2", 1'b1, 4'h1, 1'b0, 1'b0, 3'd0);
    step("f_rel0b", 1'b1, 4'h0, 1'b0, 1'b0, 3'd0);
    step("f_done", 1'b1, 4'h0, 1'b1, 1'b0, 3'd0);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
